// File: rtl/chess_display_driver.sv
// Chess-timer display driver: snapshots both players' times once per scan frame, converts
// them to BCD with a serial double-dabble engine and multiplexes "MM.SS MM.SS" onto 8 digits.
module chess_display_driver #(
  parameter int unsigned VAL_W       = 6,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [VAL_W-1:0] min1,
  input  logic [VAL_W-1:0] seg1,
  input  logic [VAL_W-1:0] min2,
  input  logic [VAL_W-1:0] seg2,
  output logic [7:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned CW = $clog2(VAL_W + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StNext} conv_state_e;

  function automatic logic [7:0] dabble(input logic [7:0] b, input logic bit_in);
    logic [7:0] a;
    a = b;
    if (a[3:0] > 4'd4) a[3:0] = a[3:0] + 4'd3;
    if (a[7:4] > 4'd4) a[7:4] = a[7:4] + 4'd3;
    return {a[6:0], bit_in};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    unique case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [RW-1:0]    refresh_cnt_q;
  logic [2:0]       digit_q;
  logic [BW-1:0]    blink_cnt_q;
  logic             blink_q;
  logic             first_q;
  logic [VAL_W-1:0] snap_q [4];
  logic [1:0]       val_idx_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [VAL_W-1:0] bin_q;
  logic [7:0]       bcd_q;
  logic [7:0]       stage_q [4];
  logic [7:0]       disp_q [4];
  logic             valid_q;
  conv_state_e      state_q, state_d;

  logic tick, frame_start, start, commit_frame;
  logic do_load, do_shift, do_store, done;

  assign tick         = enable && (refresh_cnt_q == RW'(REFRESH_DIV - 1));
  assign frame_start  = tick && (digit_q == 3'd0);
  assign start        = enable && (first_q || frame_start) && (state_q == StIdle);
  // Later results wait for a frame boundary so one frame never mixes two samples.
  assign commit_frame = frame_start && (state_q == StIdle) && valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      digit_q       <= 3'd7;
    end else if (enable) begin
      if (tick) begin
        refresh_cnt_q <= '0;
        digit_q       <= digit_q - 3'd1;
      end else begin
        refresh_cnt_q <= refresh_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = (VAL_W > 1) ? StShift : StNext;
      StShift: if (bit_cnt_q == CW'(VAL_W - 1)) state_d = StNext;
      StNext:  state_d = (val_idx_q == 2'd3) ? StIdle : StLoad;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    do_load  = (state_q == StLoad);
    do_shift = (state_q == StShift);
    do_store = (state_q == StNext);
    done     = (state_q == StNext) && (val_idx_q == 2'd3);
  end

  // LOAD also performs the first iteration: a cleared BCD register needs no adjust.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q   <= 1'b1;
      val_idx_q <= '0;
      bit_cnt_q <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        snap_q[i]  <= '0;
        stage_q[i] <= '0;
        disp_q[i]  <= '0;
      end
    end else begin
      if (start) begin
        snap_q[0] <= min1;
        snap_q[1] <= seg1;
        snap_q[2] <= min2;
        snap_q[3] <= seg2;
        first_q   <= 1'b0;
      end
      if (do_load) begin
        bin_q     <= snap_q[val_idx_q] << 1;
        bcd_q     <= {7'd0, snap_q[val_idx_q][VAL_W-1]};
        bit_cnt_q <= CW'(1);
      end
      if (do_shift) begin
        bcd_q     <= dabble(bcd_q, bin_q[VAL_W-1]);
        bin_q     <= bin_q << 1;
        bit_cnt_q <= bit_cnt_q + CW'(1);
      end
      if (do_store) begin
        stage_q[val_idx_q] <= bcd_q;
        val_idx_q          <= val_idx_q + 2'd1;
      end
      if (done && !valid_q) begin
        for (int i = 0; i < 3; i++) disp_q[i] <= stage_q[i];
        disp_q[3] <= bcd_q;
        valid_q   <= 1'b1;
      end else if (commit_frame) begin
        for (int i = 0; i < 4; i++) disp_q[i] <= stage_q[i];
      end
    end
  end

  logic [1:0] vsel;
  logic [7:0] cur;
  logic [3:0] nib;
  logic       zero1, zero2, lit;

  assign vsel  = ~digit_q[2:1];
  assign cur   = disp_q[vsel];
  assign nib   = digit_q[0] ? cur[7:4] : cur[3:0];
  assign zero1 = (disp_q[0] == 8'h00) && (disp_q[1] == 8'h00);
  assign zero2 = (disp_q[2] == 8'h00) && (disp_q[3] == 8'h00);
  assign lit   = enable && valid_q && !(blink_q && (digit_q[2] ? zero1 : zero2));

  always_comb begin
    an  = 8'hFF;
    seg = 7'h7F;
    dp  = 1'b1;
    if (lit) begin
      an  = ~(8'h01 << digit_q);
      seg = seg_code(nib);
      dp  = ~((digit_q == 3'd6) || (digit_q == 3'd2));
    end
  end

endmodule

// File: tb/tb_chess_display_driver.sv
// Bench for chess_display_driver: decodes scanned frames back to digits and compares them
// with decimal digits of the applied times, plus reset, enable, blink and tearing scenarios.
module tb_chess_display_driver;

  localparam int unsigned VAL_W = 6;
  localparam int unsigned RD    = 4;
  localparam int unsigned BD    = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [VAL_W-1:0] min1 = '0, seg1 = '0, min2 = '0, seg2 = '0;
  logic [7:0]       an;
  logic [6:0]       seg;
  logic             dp;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  chess_display_driver #(
    .VAL_W      (VAL_W),
    .REFRESH_DIV(RD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .min1  (min1),
    .seg1  (seg1),
    .min2  (min2),
    .seg2  (seg2),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; blink phase is (ncyc / BD) % 2.
  always @(posedge clk) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  function automatic int decode(input logic [6:0] s);
    case (s)
      7'b1000000: return 0;
      7'b1111001: return 1;
      7'b0100100: return 2;
      7'b0110000: return 3;
      7'b0011001: return 4;
      7'b0010010: return 5;
      7'b0000010: return 6;
      7'b1111000: return 7;
      7'b0000000: return 8;
      7'b0010000: return 9;
      default:    return 15;
    endcase
  endfunction

  function automatic int exp_digit(input int k, input int m1, input int s1, input int m2,
                                   input int s2);
    int v;
    v = (k >= 6) ? m1 : (k >= 4) ? s1 : (k >= 2) ? m2 : s2;
    return (k % 2 == 1) ? v / 10 : v % 10;
  endfunction

  task automatic set_vals(input int a, input int b, input int c, input int d);
    min1 = 6'(a);
    seg1 = 6'(b);
    min2 = 6'(c);
    seg2 = 6'(d);
  endtask

  task automatic wait_slot7(output bit ok);
    logic [7:0] prev;
    ok   = 1'b0;
    prev = an;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (an == 8'h7F && prev != 8'h7F) begin
        ok = 1'b1;
        break;
      end
      prev = an;
    end
  endtask

  // Observes one whole frame from the first cycle of digit 7 to the last cycle of digit 0.
  task automatic capture(output int d[8], output logic [7:0] dpl, output bit ok);
    bit         s_ok;
    logic [7:0] e;
    dpl = 8'h00;
    for (int k = 0; k < 8; k++) d[k] = -1;
    wait_slot7(s_ok);
    ok = s_ok;
    if (s_ok) begin
      for (int s = 7; s >= 0; s--) begin
        for (int c = 0; c < int'(RD); c++) begin
          if (!(s == 7 && c == 0)) @(negedge clk);
          e = 8'h01 << s;
          e = ~e;
          if (an !== e) ok = 1'b0;
          if (c == 0) begin
            d[s]   = decode(seg);
            dpl[s] = ~dp;
          end else if (decode(seg) != d[s] || dpl[s] != ~dp) begin
            ok = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    int         d[8];
    logic [7:0] dpl;
    bit         ok, lit;
    int         n;
    rst    = 1'b1;
    enable = 1'b1;
    set_vals(5, 9, 10, 0);
    repeat (3) @(negedge clk);
    total++; if (an !== 8'hFF) begin bad++; $display("FAIL reset_an: got %h want ff", an); end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL reset_seg: got %h want 7f", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp: got %b want 1", dp); end
    rst = 1'b0;
    n   = 0;
    lit = 1'b0;
    for (int i = 1; i <= int'(8 * RD + 4); i++) begin
      @(negedge clk);
      if (an !== 8'hFF) begin
        n   = i;
        lit = 1'b1;
        break;
      end
    end
    total++;
    if (!lit || n > int'(8 * RD + 2)) begin
      bad++; $display("FAIL reset_valid_latency: got %0d cycles want <= %0d", n, 8 * RD + 2);
    end
    capture(d, dpl, ok);
    total++; if (!ok) begin bad++; $display("FAIL reset_scan_shape: got bad want ok"); end
    for (int k = 7; k >= 0; k--) begin
      total++;
      if (d[k] !== exp_digit(k, 5, 9, 10, 0)) begin
        bad++; $display("FAIL reset_digit%0d: got %0d want %0d", k, d[k], exp_digit(k, 5, 9, 10, 0));
      end
    end
    total++;
    if (dpl !== 8'b0100_0100) begin bad++; $display("FAIL reset_dp_map: got %b want 01000100", dpl); end
  endtask

  task automatic test_conversions();
    int         d[8];
    logic [7:0] dpl;
    bit         ok;
    int         m1, s1, m2, s2;
    for (int i = 0; i < 7; i++) begin
      m1 = 7;
      s1 = (i == 0) ? 59 : (i == 1) ? 63 : 0;
      m2 = 12;
      s2 = 34;
      if (i >= 3) begin
        m1 = int'($urandom_range(1, 63));
        s1 = int'($urandom_range(0, 63));
        m2 = int'($urandom_range(1, 63));
        s2 = int'($urandom_range(0, 63));
      end
      set_vals(m1, s1, m2, s2);
      repeat (16 * RD) @(negedge clk);
      capture(d, dpl, ok);
      total++; if (!ok) begin bad++; $display("FAIL conv_scan_shape[%0d]: got bad want ok", i); end
      for (int k = 0; k < 8; k++) begin
        total++;
        if (d[k] !== exp_digit(k, m1, s1, m2, s2)) begin
          bad++;
          $display("FAIL conv[%0d] digit%0d (%0d %0d %0d %0d): got %0d want %0d", i, k, m1, s1,
                   m2, s2, d[k], exp_digit(k, m1, s1, m2, s2));
        end
      end
    end
  endtask

  task automatic test_tear();
    int         d[8];
    logic [7:0] dpl;
    bit         ok, seen, mo, mn;
    int         old_v, new_v;
    for (int p = 0; p < 2; p++) begin
      old_v = (p == 0) ? 31 : 30;
      new_v = (p == 0) ? 30 : 29;
      set_vals(20, 45, 8, old_v);
      repeat (16 * RD) @(negedge clk);
      capture(d, dpl, ok);
      total++;
      if (!ok || d[1] !== old_v / 10 || d[0] !== old_v % 10) begin
        bad++; $display("FAIL tear_pre[%0d]: got %0d%0d want %0d", p, d[1], d[0], old_v);
      end
      wait_slot7(ok);
      repeat (10) @(negedge clk);
      set_vals(20, 45, 8, new_v);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (an == 8'hFD) begin seen = 1'b1; break; end
      end
      total++;
      if (!seen || decode(seg) !== old_v / 10) begin
        bad++; $display("FAIL tear_rest_tens[%0d]: got %0d want %0d", p, decode(seg), old_v / 10);
      end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (an == 8'hFE) begin seen = 1'b1; break; end
      end
      total++;
      if (!seen || decode(seg) !== old_v % 10) begin
        bad++; $display("FAIL tear_rest_units[%0d]: got %0d want %0d", p, decode(seg), old_v % 10);
      end
      capture(d, dpl, ok);
      mo = 1'b1;
      mn = 1'b1;
      for (int k = 0; k < 8; k++) begin
        if (d[k] != exp_digit(k, 20, 45, 8, old_v)) mo = 1'b0;
        if (d[k] != exp_digit(k, 20, 45, 8, new_v)) mn = 1'b0;
      end
      total++;
      if (!ok || !(mo || mn)) begin
        bad++; $display("FAIL tear_mix[%0d]: got seg2 %0d%0d want %0d or %0d", p, d[1], d[0],
                        old_v, new_v);
      end
      capture(d, dpl, ok);
      for (int k = 0; k < 8; k++) begin
        total++;
        if (d[k] !== exp_digit(k, 20, 45, 8, new_v)) begin
          bad++; $display("FAIL tear_post[%0d] digit%0d: got %0d want %0d", p, k, d[k],
                          exp_digit(k, 20, 45, 8, new_v));
        end
      end
    end
  endtask

  task automatic test_blink();
    int p1_on_ph1, p1_on_ph0, p2_on_ph0, ph;
    p1_on_ph1 = 0;
    p1_on_ph0 = 0;
    p2_on_ph0 = 0;
    set_vals(3, 17, 0, 0);
    repeat (24 * RD) @(negedge clk);
    for (int i = 0; i < int'(4 * BD); i++) begin
      @(negedge clk);
      ph = (ncyc / int'(BD)) % 2;
      if (ph == 1) begin
        total++;
        if (an[3:0] !== 4'hF) begin
          bad++; $display("FAIL blink_p2_dark at cycle %0d: got an %h want an[3:0]=f", ncyc, an);
        end
        if (an[7:4] != 4'hF) p1_on_ph1++;
      end else begin
        if (an[7:4] != 4'hF) p1_on_ph0++;
        if (an[3:0] != 4'hF) begin
          p2_on_ph0++;
          total++;
          if (decode(seg) !== 0) begin
            bad++; $display("FAIL blink_p2_digit: got %0d want 0", decode(seg));
          end
        end
      end
    end
    total++; if (p1_on_ph1 == 0) begin bad++; $display("FAIL blink_p1_ph1: got 0 lit want >0"); end
    total++; if (p1_on_ph0 == 0) begin bad++; $display("FAIL blink_p1_ph0: got 0 lit want >0"); end
    total++; if (p2_on_ph0 == 0) begin bad++; $display("FAIL blink_p2_ph0: got 0 lit want >0"); end
  endtask

  task automatic test_enable();
    bit         ok, okseq, reached;
    int         exp_d, run;
    logic [7:0] e, e_next;
    set_vals(45, 12, 33, 7);
    repeat (16 * RD) @(negedge clk);
    wait_slot7(ok);
    repeat (5) @(negedge clk);
    total++;
    if (!ok || an !== 8'hBF) begin bad++; $display("FAIL en_pre_digit: got %h want bf", an); end
    enable = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      total++; if (an !== 8'hFF) begin bad++; $display("FAIL en_off_an: got %h want ff", an); end
      total++; if (seg !== 7'h7F) begin bad++; $display("FAIL en_off_seg: got %h want 7f", seg); end
      total++; if (dp !== 1'b1) begin bad++; $display("FAIL en_off_dp: got %b want 1", dp); end
    end
    @(negedge clk);
    enable = 1'b1;
    #1;
    exp_d   = 6;
    run     = 0;
    okseq   = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 40; i++) begin
      e      = ~(8'h01 << exp_d);
      e_next = (exp_d > 0) ? ~(8'h01 << (exp_d - 1)) : 8'h7F;
      if (an == e) begin
        run++;
      end else if (an == e_next) begin
        if (exp_d == 6 && (run < 1 || run > int'(RD))) okseq = 1'b0;
        if (exp_d != 6 && run != int'(RD)) okseq = 1'b0;
        if (exp_d == 0) begin
          reached = 1'b1;
          break;
        end
        exp_d--;
        run = 1;
      end else begin
        okseq = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (!okseq || !reached) begin
      bad++; $display("FAIL en_resume: got stuck at digit %0d run %0d an %h want 6..0 order", exp_d,
                      run, an);
    end
  endtask

  task automatic test_reset_mid();
    int         d[8];
    logic [7:0] dpl, e;
    bit         ok, lit;
    int         m1, s1, m2, s2, k_lit;
    set_vals(int'($urandom_range(1, 63)), int'($urandom_range(0, 63)),
             int'($urandom_range(1, 63)), int'($urandom_range(0, 63)));
    repeat (16 * RD) @(negedge clk);
    wait_slot7(ok);
    @(negedge clk);
    total++;
    if (!ok || an !== 8'h7F) begin bad++; $display("FAIL rstmid_pre: got %h want 7f", an); end
    m1 = int'($urandom_range(1, 63));
    s1 = int'($urandom_range(0, 63));
    m2 = int'($urandom_range(1, 63));
    s2 = int'($urandom_range(0, 63));
    set_vals(m1, s1, m2, s2);
    rst = 1'b1;
    #1;
    total++; if (an !== 8'hFF) begin bad++; $display("FAIL rstmid_an: got %h want ff", an); end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL rstmid_seg: got %h want 7f", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL rstmid_dp: got %b want 1", dp); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lit = 1'b0;
    for (int i = 0; i < int'(8 * RD + 4); i++) begin
      @(negedge clk);
      if (an !== 8'hFF) begin lit = 1'b1; break; end
    end
    k_lit = -1;
    for (int k = 0; k < 8; k++) begin
      e = ~(8'h01 << k);
      if (an == e) k_lit = k;
    end
    total++;
    if (!lit || k_lit < 0 || decode(seg) !== exp_digit(k_lit, m1, s1, m2, s2)) begin
      bad++; $display("FAIL rstmid_first: got an %h digit %0d want current inputs", an, decode(seg));
    end
    capture(d, dpl, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_scan_shape: got bad want ok"); end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (d[k] !== exp_digit(k, m1, s1, m2, s2)) begin
        bad++; $display("FAIL rstmid_digit%0d: got %0d want %0d", k, d[k],
                        exp_digit(k, m1, s1, m2, s2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_conversions();
    test_tear();
    test_blink();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
